// File: rtl/pipe_stage_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// slave = the stage itself, master = the environment driving it.
interface pipe_stage_if #(
    parameter int DATA_W = 64
);
    logic              flush_i;
    logic              up_valid_i;
    logic              up_ready_o;
    logic [DATA_W-1:0] up_data_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [DATA_W-1:0] dn_data_o;
    logic [1:0]        occupancy_o;

    modport slave (
        input  flush_i, up_valid_i, up_data_i, dn_ready_i,
        output up_ready_o, dn_valid_o, dn_data_o, occupancy_o
    );

    modport master (
        output flush_i, up_valid_i, up_data_i, dn_ready_i,
        input  up_ready_o, dn_valid_o, dn_data_o, occupancy_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register (IF/ID style) with flush and bubble insertion.
// Optional skid slot enabled by defining PIPE_STAGE_SKID_EN (registered up_ready_o).
module pipe_stage_reg #(
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {32'h0, 32'h00000013}
) (
    input  logic         clk,
    input  logic         rst,
    pipe_stage_if.slave  bus
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              up_ready;
    logic              dn_valid;
    logic              up_fire;
    logic              dn_fire;

    assign dn_valid = (state_q != EMPTY);

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;

    // Depends only on state, so dn_ready_i never reaches up_ready_o.
    assign up_ready = (state_q != TWO);
`else
    assign up_ready = !dn_valid || bus.dn_ready_i;
`endif

    assign up_fire = bus.up_valid_i && up_ready;
    assign dn_fire = dn_valid && bus.dn_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (bus.flush_i) begin
            state_d = EMPTY;
            head_d  = BUBBLE_DATA;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_fire) begin
                        state_d = ONE;
                        head_d  = bus.up_data_i;
                    end
                end
                ONE: begin
                    if (up_fire && dn_fire) begin
                        head_d = bus.up_data_i;
                    end else if (dn_fire) begin
                        state_d = EMPTY;
                        head_d  = BUBBLE_DATA;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (up_fire) begin
                        state_d = TWO;
                        skid_d  = bus.up_data_i;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: begin
                    if (dn_fire) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                    head_d  = BUBBLE_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= BUBBLE_DATA;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= BUBBLE_DATA;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    assign bus.up_ready_o  = up_ready;
    assign bus.dn_valid_o  = dn_valid;
    assign bus.dn_data_o   = head_q;
    assign bus.occupancy_o = state_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width in bits (bits 63:32 = pc_plus_4, 31:0 = instruction in the IF/ID use).
REQ-002 SHALL have parameter BUBBLE_DATA, default {32'h0, 32'h00000013}, payload presented when empty or flushed (PC 0, NOP).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush_i  in  1  discard all held and incoming beats.
REQ-006 SHALL have port up_valid_i  in  1  upstream beat valid.
REQ-007 SHALL have port up_ready_o  out  1  stage can accept a beat.
REQ-008 SHALL have port up_data_i  in  DATA_W  upstream payload.
REQ-009 SHALL have port dn_valid_o  out  1  downstream beat valid.
REQ-010 SHALL have port dn_ready_i  in  1  downstream accepts (low = stall).
REQ-011 SHALL have port dn_data_o  out  DATA_W  downstream payload.
REQ-012 SHALL have port occupancy_o  out  2  number of held beats (0..2).

Function
REQ-013 SHALL treat a beat as transferred upstream when up_valid_i && up_ready_o at a rising edge, and downstream when dn_valid_o && dn_ready_i.
REQ-014 SHALL deliver beats downstream in acceptance order; no beat is duplicated or lost except by flush.
REQ-015 SHALL implement states EMPTY (occ 0), ONE (occ 1) and, when skid is compiled in, TWO (occ 2); occupancy_o SHALL equal the state's count.
REQ-016 SHALL drive dn_valid_o = (state != EMPTY) and dn_data_o from the head register only (no combinational path from up_data_i).
REQ-017 SHALL transition EMPTY: up fire -> ONE (head <= up_data_i); otherwise stay.
REQ-018 SHALL transition ONE: up+dn fire -> ONE (head <= up_data_i); dn only -> EMPTY; up only -> TWO (skid <= up_data_i) or, without skid, not possible; neither -> stay.
REQ-019 SHALL transition TWO: dn fire -> ONE (head <= skid); otherwise stay; up_ready_o is 0 so no up fire can occur.
REQ-020 SHALL load head with BUBBLE_DATA on every transition into EMPTY, so dn_data_o == BUBBLE_DATA whenever dn_valid_o == 0.
REQ-021 SHALL, with flush_i high at an edge, go to EMPTY, load head with BUBBLE_DATA, and discard any beat that fires upstream in that cycle; flush SHALL take priority over all other transitions.
REQ-022 SHALL, with flush_i high and dn_ready_i low (stall), still flush; flush has priority over stall.
REQ-023 SHALL, in the cycle after a flush, accept upstream beats normally.
REQ-024 SHALL make every output a pure function of registered state, except up_ready_o in the non-skid build (REQ-030).

Reset
REQ-025 SHALL, when rst is high at a rising edge, enter EMPTY, load head and skid with BUBBLE_DATA, and drive dn_valid_o=0, occupancy_o=0, dn_data_o=BUBBLE_DATA.
REQ-026 SHALL give rst priority over flush_i and all handshakes, including reset asserted mid-transfer in state TWO.
REQ-027 SHALL drive up_ready_o=1 in the first cycle after reset release.

Configuration
REQ-028 SHALL compile the skid buffer only when macro PIPE_STAGE_SKID_EN is defined.
REQ-029 SHALL, with PIPE_STAGE_SKID_EN defined, use states EMPTY/ONE/TWO and drive up_ready_o = (state != TWO), registered, with no combinational path from dn_ready_i to up_ready_o.
REQ-030 SHALL, without PIPE_STAGE_SKID_EN, omit the skid register and TWO, drive up_ready_o = !dn_valid_o || dn_ready_i (combinational), and cap occupancy_o at 1.

Verification
REQ-031 SHALL check reset: rst=1 for 2 edges, then 0 -> dn_valid_o=0, dn_data_o=64'h0000000000000013, occupancy_o=0, up_ready_o=1.
REQ-032 SHALL check flow: beats 64'h00000004_00a00093 then 64'h00000008_00508113 with dn_ready_i=1 -> each appears on dn_data_o one cycle after acceptance, in order.
REQ-033 SHALL check stall (skid build): dn_ready_i=0, 3 beats offered -> first two accepted, occupancy_o=2, up_ready_o=0; release -> 2 beats out in order, then the third.
REQ-034 SHALL check stall (non-skid build): dn_ready_i=0 while holding 64'h0000000C_001101b3 -> up_ready_o=0, output holds until dn_ready_i=1.
REQ-035 SHALL check flush vs stall: occupancy 2, flush_i=1, dn_ready_i=0, up_valid_i=1 with 64'h00000010_01400213 -> next cycle dn_valid_o=0, dn_data_o=BUBBLE_DATA, occupancy_o=0, beat 0x10 never emitted.
REQ-036 SHALL check post-flush recovery: after flush, beat 64'h00000014_00400023 -> emitted next cycle with dn_valid_o=1.
